// File: rtl/fir_coef_loader_if.sv
// fir_coef_loader_if
//   Bundles the coefficient-load handshake, the DA-engine coefficient bus,
//   and the sample-strobe gating signals of fir_coef_loader.
//   master : host/upstream side (drives cfg_*, da_busy, valid_in)
//   slave  : loader side (drives cfg_ready, valid_gated, CIN/CADDR/CLOAD,
//            cfg_done, cfg_err, word_cnt, drop_cnt)
interface fir_coef_loader_if;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [19:0] cfg_data;
   logic [10:0] cfg_addr;
   logic        cfg_last;
   logic        da_busy;
   logic        valid_in;
   logic        valid_gated;
   logic [19:0] CIN;
   logic [10:0] CADDR;
   logic        CLOAD;
   logic        cfg_done;
   logic        cfg_err;
   logic [11:0] word_cnt;
   logic [7:0]  drop_cnt;

   modport master (
      output cfg_valid, cfg_data, cfg_addr, cfg_last, da_busy, valid_in,
      input  cfg_ready, valid_gated, CIN, CADDR, CLOAD, cfg_done, cfg_err,
             word_cnt, drop_cnt
   );

   modport slave (
      input  cfg_valid, cfg_data, cfg_addr, cfg_last, da_busy, valid_in,
      output cfg_ready, valid_gated, CIN, CADDR, CLOAD, cfg_done, cfg_err,
             word_cnt, drop_cnt
   );
endinterface

// File: rtl/fir_coef_loader.sv
// fir_coef_loader
//   Loads coefficient bursts from a host into a distributed-arithmetic FIR
//   engine. A burst waits for the engine to go idle (DRAIN), streams words
//   (LOAD), then commits (COMMIT). While a burst is in progress the sample
//   strobe to the filter controller is blocked and blocked samples are counted.
// Ports
//   clk    : single clock
//   resetn : asynchronous active-low reset
//   bus    : fir_coef_loader_if.slave (handshake, coefficient bus, gating)
// Parameters
//   COEF_MAX : highest legal coefficient address
//   TIMEOUT  : idle cycles allowed in LOAD before the burst is force-committed
module fir_coef_loader #(
   parameter int COEF_MAX = 2047,
   parameter int TIMEOUT  = 255
) (
   input logic               clk,
   input logic               resetn,
   fir_coef_loader_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, DRAIN, LOAD, COMMIT} state_t;

   // Idle counter holds 0..TIMEOUT-1; reaching TIMEOUT-1 with another idle
   // cycle means TIMEOUT consecutive idle cycles have elapsed.
   localparam int                IDLE_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
   localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
   localparam logic [11:0]       COEF_MAX_L = 12'(COEF_MAX);
   localparam logic [11:0]       WORD_LIMIT = 12'd2047;  // count before the 2048th write

   state_t            state_reg;
   logic [19:0]       cin_reg;
   logic [10:0]       caddr_reg;
   logic              cload_reg;
   logic              done_reg;
   logic              err_reg;
   logic [11:0]       word_cnt_reg;   // latched result of last committed burst
   logic [11:0]       wcnt_reg;       // running count within the current burst
   logic [IDLE_W-1:0] idle_cnt_reg;
   logic [7:0]        drop_cnt_reg;

   logic in_range;
   assign in_range = ({1'b0, bus.cfg_addr} <= COEF_MAX_L);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= IDLE;
         cin_reg      <= '0;
         caddr_reg    <= '0;
         cload_reg    <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         word_cnt_reg <= '0;
         wcnt_reg     <= '0;
         idle_cnt_reg <= '0;
         drop_cnt_reg <= '0;
      end else begin
         cload_reg <= 1'b0;
         done_reg  <= 1'b0;

         if (bus.valid_in && (state_reg != IDLE) && (drop_cnt_reg != 8'hFF))
            drop_cnt_reg <= drop_cnt_reg + 8'd1;

         case (state_reg)
            IDLE: begin
               if (bus.cfg_valid) begin
                  state_reg    <= DRAIN;
                  err_reg      <= 1'b0;
                  wcnt_reg     <= '0;
                  idle_cnt_reg <= '0;
               end
            end

            DRAIN: begin
               if (!bus.da_busy)
                  state_reg <= LOAD;
            end

            LOAD: begin
               // cfg_ready is high throughout LOAD, so cfg_valid means accepted
               if (bus.cfg_valid) begin
                  idle_cnt_reg <= '0;
                  if (in_range) begin
                     cin_reg   <= bus.cfg_data;
                     caddr_reg <= bus.cfg_addr;
                     cload_reg <= 1'b1;
                     wcnt_reg  <= wcnt_reg + 12'd1;
                  end else begin
                     err_reg <= 1'b1;   // out-of-range word is consumed, not written
                  end
                  if (bus.cfg_last) begin
                     state_reg <= COMMIT;
                  end else if (in_range && (wcnt_reg == WORD_LIMIT)) begin
                     // 2048th word written without cfg_last: force commit
                     state_reg <= COMMIT;
                     err_reg   <= 1'b1;
                  end
               end else if (idle_cnt_reg == IDLE_LAST) begin
                  state_reg <= COMMIT;
                  err_reg   <= 1'b1;
               end else begin
                  idle_cnt_reg <= idle_cnt_reg + IDLE_ONE;
               end
            end

            COMMIT: begin
               done_reg     <= 1'b1;
               word_cnt_reg <= wcnt_reg;
               state_reg    <= IDLE;   // cfg_valid here waits until IDLE
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.cfg_ready   = (state_reg == LOAD);
   assign bus.valid_gated = (state_reg == IDLE) ? bus.valid_in : 1'b0;
   assign bus.CIN         = cin_reg;
   assign bus.CADDR       = caddr_reg;
   assign bus.CLOAD       = cload_reg;
   assign bus.cfg_done    = done_reg;
   assign bus.cfg_err     = err_reg;
   assign bus.word_cnt    = word_cnt_reg;
   assign bus.drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader
//   Scoreboard bench for fir_coef_loader (COEF_MAX=15, TIMEOUT=4).
//   Stimulus pushes expected coefficient writes and burst results into
//   queues; a negedge monitor pops and compares on every CLOAD / cfg_done.
module tb_fir_coef_loader;
   logic clk = 1'b0;
   logic resetn;
   int   total = 0;
   int   bad   = 0;
   int   exp_drop = 0;
   logic [30:0] wr_q[$];     // {addr, data}
   logic [12:0] done_q[$];   // {err, word_cnt}

   fir_coef_loader_if bif();

   fir_coef_loader #(.COEF_MAX(15), .TIMEOUT(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bif.slave)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Bench model of the address check: only in-range words produce a write.
   function automatic void exp_wr(logic [19:0] d, logic [10:0] a);
      if (a <= 11'd15) wr_q.push_back({a, d});
   endfunction

   task automatic send(input logic [19:0] d, input logic [10:0] a, input logic l);
      int guard = 0;
      exp_wr(d, a);
      bif.cfg_valid = 1'b1;
      bif.cfg_data  = d;
      bif.cfg_addr  = a;
      bif.cfg_last  = l;
      while (bif.cfg_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) chk("send_ready_wait", 32'(bif.cfg_ready), 1);
      @(posedge clk); #1;
      bif.cfg_valid = 1'b0;
      bif.cfg_last  = 1'b0;
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (bif.CLOAD === 1'b1) begin
            if (wr_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_cload: CADDR=%0d CIN=0x%0h, no write queued", bif.CADDR, bif.CIN);
            end else begin
               logic [30:0] e;
               e = wr_q.pop_front();
               chk("cload_caddr", 32'(bif.CADDR), 32'(e[30:20]));
               chk("cload_cin",   32'(bif.CIN),   32'(e[19:0]));
            end
         end
         if (bif.cfg_done === 1'b1) begin
            if (done_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: word_cnt=%0d cfg_err=%0d", bif.word_cnt, bif.cfg_err);
            end else begin
               logic [12:0] e;
               e = done_q.pop_front();
               $display("burst done: word_cnt=%0d cfg_err=%0d (expected %0d/%0d)",
                        bif.word_cnt, bif.cfg_err, e[11:0], e[12]);
               chk("done_word_cnt", 32'(bif.word_cnt), 32'(e[11:0]));
               chk("done_cfg_err",  32'(bif.cfg_err),  32'(e[12]));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // ---------------- reset state ----------------
      resetn        = 1'b0;
      bif.cfg_valid = 1'b0;
      bif.cfg_data  = '0;
      bif.cfg_addr  = '0;
      bif.cfg_last  = 1'b0;
      bif.da_busy   = 1'b0;
      bif.valid_in  = 1'b1;
      #22;
      chk("rst_cfg_ready",   32'(bif.cfg_ready), 0);
      chk("rst_cload",       32'(bif.CLOAD), 0);
      chk("rst_cin",         32'(bif.CIN), 0);
      chk("rst_caddr",       32'(bif.CADDR), 0);
      chk("rst_cfg_done",    32'(bif.cfg_done), 0);
      chk("rst_cfg_err",     32'(bif.cfg_err), 0);
      chk("rst_word_cnt",    32'(bif.word_cnt), 0);
      chk("rst_drop_cnt",    32'(bif.drop_cnt), 0);
      chk("rst_valid_gated", 32'(bif.valid_gated), 1);
      @(posedge clk); #1;
      resetn = 1'b1;
      chk("release_valid_gated", 32'(bif.valid_gated), 1);
      @(posedge clk); #1;
      chk("first_cycle_valid_gated", 32'(bif.valid_gated), 1);
      chk("idle_no_drop", 32'(bif.drop_cnt), 0);
      bif.valid_in = 1'b0;

      // ---------------- 3-word burst ----------------
      done_q.push_back({1'b0, 12'd3});
      send(20'h00001, 11'd0, 1'b0);
      send(20'h7FFFF, 11'd1, 1'b0);
      send(20'h80000, 11'd2, 1'b1);
      chk("burst3_last_cload", 32'(bif.CLOAD), 1);
      chk("burst3_done_not_yet", 32'(bif.cfg_done), 0);
      @(posedge clk); #1;
      chk("burst3_done_next_cycle", 32'(bif.cfg_done), 1);
      chk("burst3_cload_low", 32'(bif.CLOAD), 0);
      repeat (3) @(posedge clk);
      #1;

      // ---------------- DRAIN held by da_busy ----------------
      bif.da_busy   = 1'b1;
      bif.cfg_valid = 1'b1;
      bif.cfg_data  = 20'h00005;
      bif.cfg_addr  = 11'd3;
      bif.cfg_last  = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         chk("drain_ready_low", 32'(bif.cfg_ready), 0);
         bif.valid_in = (i % 2 == 0);
         chk("drain_valid_gated_low", 32'(bif.valid_gated), 0);
         if (i % 2 == 0) exp_drop++;
         @(posedge clk); #1;
      end
      bif.valid_in = 1'b0;
      bif.da_busy  = 1'b0;
      chk("drain_ready_still_low", 32'(bif.cfg_ready), 0);
      exp_wr(20'h00005, 11'd3);
      done_q.push_back({1'b0, 12'd1});
      @(posedge clk); #1;
      chk("load_after_busy_falls", 32'(bif.cfg_ready), 1);
      chk("drop_after_drain", 32'(bif.drop_cnt), 32'(exp_drop));
      @(posedge clk); #1;
      bif.cfg_valid = 1'b0;
      bif.cfg_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // ---------------- out-of-range address ----------------
      done_q.push_back({1'b1, 12'd2});
      send(20'h0AAAA, 11'd14, 1'b0);
      send(20'h0BBBB, 11'd16, 1'b0);
      send(20'h0CCCC, 11'd15, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // ---------------- LOAD timeout ----------------
      done_q.push_back({1'b1, 12'd1});
      bif.cfg_valid = 1'b1;
      bif.cfg_addr  = 11'd7;
      @(posedge clk); #1;
      chk("err_cleared_on_start", 32'(bif.cfg_err), 0);
      send(20'h12345, 11'd7, 1'b0);
      n = 0;
      while (bif.cfg_done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("timeout_done_latency", 32'(n), 5);
      repeat (2) @(posedge clk);
      #1;

      // ---------------- 2048-word limit ----------------
      done_q.push_back({1'b1, 12'd2048});
      for (int i = 0; i < 2048; i++) send(20'(i), 11'(i % 16), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("limit_word_cnt_out", 32'(bif.word_cnt), 2048);

      // ---------------- reset mid-burst ----------------
      for (int i = 0; i < 5; i++) send(20'h00100 + 20'(i), 11'(i), 1'b0);
      @(negedge clk); #1;
      resetn   = 1'b0;
      exp_drop = 0;
      bif.valid_in = 1'b1;
      #1;
      chk("midrst_cfg_ready", 32'(bif.cfg_ready), 0);
      chk("midrst_cload",     32'(bif.CLOAD), 0);
      chk("midrst_cin",       32'(bif.CIN), 0);
      chk("midrst_caddr",     32'(bif.CADDR), 0);
      chk("midrst_cfg_done",  32'(bif.cfg_done), 0);
      chk("midrst_cfg_err",   32'(bif.cfg_err), 0);
      chk("midrst_word_cnt",  32'(bif.word_cnt), 0);
      chk("midrst_drop_cnt",  32'(bif.drop_cnt), 0);
      chk("midrst_valid_gated", 32'(bif.valid_gated), 1);
      bif.valid_in = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      done_q.push_back({1'b0, 12'd2});
      send(20'h00AB4, 11'd4, 1'b0);
      send(20'h00AB5, 11'd5, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // ---------------- drop_cnt saturation, cfg_valid in COMMIT ----------------
      bif.da_busy   = 1'b1;
      bif.cfg_valid = 1'b1;
      bif.cfg_addr  = 11'd0;
      @(posedge clk); #1;
      bif.valid_in = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (i == 253) chk("drop_cnt_254", 32'(bif.drop_cnt), 254);
      end
      chk("drop_cnt_saturated", 32'(bif.drop_cnt), 255);
      bif.valid_in = 1'b0;
      bif.da_busy  = 1'b0;
      done_q.push_back({1'b0, 12'd1});
      done_q.push_back({1'b0, 12'd1});
      send(20'h00055, 11'd0, 1'b1);
      send(20'h00066, 11'd9, 1'b1);   // raised during COMMIT
      repeat (4) @(posedge clk);
      #1;
      chk("drop_cnt_held", 32'(bif.drop_cnt), 255);

      chk("wr_q_drained",   32'(wr_q.size()), 0);
      chk("done_q_drained", 32'(done_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
